// File: rtl/decoder_pkg.sv
// Shared constants and decode helper for the registered 3-to-8 decoder.
// DECODER_ACTIVE_LOW_EN selects the one-cold output polarity and its reset value.
package decoder_pkg;

    localparam int SEL_W = 3;
    localparam int OUT_W = 8;

`ifdef DECODER_ACTIVE_LOW_EN
    // All lines inactive means all ones when the outputs are one-cold.
    localparam logic [OUT_W-1:0] OUT_RST = 8'hFF;
`else
    localparam logic [OUT_W-1:0] OUT_RST = 8'h00;
`endif

    function automatic logic [OUT_W-1:0] decode_onehot(input logic [SEL_W-1:0] sel);
        logic [OUT_W-1:0] one;
        one = {{(OUT_W-1){1'b0}}, 1'b1};
        return one << sel;
    endfunction

endpackage

// File: rtl/decoder_3to8_comb.sv
// Combinational 3-to-8 decode with output polarity applied.
// DECODER_ACTIVE_LOW_EN defined: one-cold output; undefined: one-hot output.
module decoder_3to8_comb
    import decoder_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] dec
);

    always_comb begin
        dec = decode_onehot(sel);
`ifdef DECODER_ACTIVE_LOW_EN
        dec = ~dec;
`endif
    end

endmodule

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 line decoder: one cycle from select inputs to output.
// Polarity and reset value follow DECODER_ACTIVE_LOW_EN (see decoder_pkg).
module decoder_3to8
    import decoder_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_1,
    input  logic             in_2,
    input  logic             in_3,
    output logic [OUT_W-1:0] out
);

    logic [SEL_W-1:0] sel;
    logic [OUT_W-1:0] dec;
    logic [OUT_W-1:0] out_d;
    logic [OUT_W-1:0] out_q;

    assign sel = {in_1, in_2, in_3};

    decoder_3to8_comb u_comb (
        .sel (sel),
        .dec (dec)
    );

    always_comb begin
        out_d = dec;
    end

    // Reset wins over the inputs at any edge where sys_rst is high.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            out_q <= OUT_RST;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: vector table, glitch, reset and random soak.
// Honours DECODER_ACTIVE_LOW_EN by inverting the expected values.
module tb_decoder_3to8;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       in_1 = 1'b1;
    logic       in_2 = 1'b0;
    logic       in_3 = 1'b1;
    logic [7:0] out_w;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic [2:0] sel;
        logic [7:0] exp_hi;
        string      name;
    } vec_t;

    vec_t vecs[$];

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [7:0] RST_EXP = 8'hFF;
    localparam bit         LOW_EN  = 1'b1;
`else
    localparam logic [7:0] RST_EXP = 8'h00;
    localparam bit         LOW_EN  = 1'b0;
`endif

    decoder_3to8 dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .in_1    (in_1),
        .in_2    (in_2),
        .in_3    (in_3),
        .out     (out_w)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] pol(input logic [7:0] hi);
        return LOW_EN ? ~hi : hi;
    endfunction

    function automatic logic [7:0] model(input logic rst, input logic [2:0] sel);
        logic [7:0] v;
        v = 8'h00;
        v[sel] = 1'b1;
        return rst ? RST_EXP : pol(v);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic [2:0] sel);
        sys_rst = rst;
        {in_1, in_2, in_3} = sel;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic apply(input logic rst, input logic [2:0] sel, input logic [7:0] exp,
                         input string name);
        logic [7:0] e;
        drive(rst, sel);
        exp_q.push_back(exp);
        @(posedge sys_clk);
        #1;
        e = exp_q.pop_front();
        check(name, out_w, e);
        @(negedge sys_clk);
    endtask

    initial begin
        logic [2:0] s;
        logic [7:0] e;

        vecs.push_back('{1'b1, 3'b101, 8'h00, "reset0"});
        vecs.push_back('{1'b1, 3'b101, 8'h00, "reset1"});
        vecs.push_back('{1'b1, 3'b101, 8'h00, "reset2"});
        vecs.push_back('{1'b0, 3'd0, 8'h01, "dec0"});
        vecs.push_back('{1'b0, 3'd1, 8'h02, "dec1"});
        vecs.push_back('{1'b0, 3'd2, 8'h04, "dec2"});
        vecs.push_back('{1'b0, 3'd3, 8'h08, "dec3"});
        vecs.push_back('{1'b0, 3'd4, 8'h10, "dec4"});
        vecs.push_back('{1'b0, 3'd5, 8'h20, "dec5"});
        vecs.push_back('{1'b0, 3'd6, 8'h40, "dec6"});
        vecs.push_back('{1'b0, 3'd7, 8'h80, "dec7"});
        vecs.push_back('{1'b0, 3'd5, 8'h20, "back5"});
        vecs.push_back('{1'b0, 3'd2, 8'h04, "back2"});

        @(negedge sys_clk);
        foreach (vecs[i]) begin
            e = vecs[i].rst ? RST_EXP : pol(vecs[i].exp_hi);
            apply(vecs[i].rst, vecs[i].sel, e, vecs[i].name);
        end

        // Glitches on the inputs between edges must not reach the output.
        apply(1'b0, 3'b011, pol(8'h08), "glitch_pre");
        drive(1'b0, 3'b011);
        #1 check("glitch_hold_a", out_w, pol(8'h08));
        drive(1'b0, 3'b110);
        #2 check("glitch_hold_b", out_w, pol(8'h08));
        drive(1'b0, 3'b011);
        exp_q.push_back(pol(8'h08));
        @(posedge sys_clk);
        #1;
        e = exp_q.pop_front();
        check("glitch_edge", out_w, e);
        drive(1'b0, 3'b110);
        #2 check("glitch_hold_c", out_w, pol(8'h08));
        drive(1'b0, 3'b011);
        #1 check("glitch_hold_d", out_w, pol(8'h08));
        @(negedge sys_clk);
        apply(1'b0, 3'b011, pol(8'h08), "glitch_post");

        // One-cycle reset in the middle of steady 111.
        apply(1'b0, 3'b111, pol(8'h80), "mid_pre");
        apply(1'b1, 3'b111, RST_EXP,    "mid_rst");
        apply(1'b0, 3'b111, pol(8'h80), "mid_release");

        // Random soak: sampled value set at the falling edge, junk after the rising edge.
        for (int c = 0; c < 1000; c++) begin
            s = 3'($urandom_range(0, 7));
            drive(1'b0, s);
            exp_q.push_back(model(1'b0, s));
            @(posedge sys_clk);
            #1;
            e = exp_q.pop_front();
            check("soak_val", out_w, e);
            check("soak_ones", 8'($countones(LOW_EN ? ~out_w : out_w)), 8'd1);
            drive(1'b0, 3'($urandom_range(0, 7)));
            @(negedge sys_clk);
        end

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
